// File: rtl/gem_cluster_lut_sequencer_if.sv
// Bus between the cluster sequencer and the pad/roll LUT converter.
// Sequencer drives cluster fields; converter returns CSC windows.
interface gem_cluster_lut_sequencer_if;
    logic [13:0] lut_cluster;
    logic        lut_vpf;
    logic [2:0]  lut_roll;
    logic [7:0]  lut_pad;
    logic [2:0]  lut_size;
    logic [5:0]  lut_wire_lo;
    logic [5:0]  lut_wire_hi;
    logic [7:0]  lut_me1bhs_lo;
    logic [7:0]  lut_me1bhs_hi;
    logic [7:0]  lut_me1ahs_lo;
    logic [7:0]  lut_me1ahs_hi;
    logic        lut_me1a;

    modport master (
        output lut_cluster, lut_vpf, lut_roll,
        output lut_pad, lut_size,
        input  lut_wire_lo, lut_wire_hi,
        input  lut_me1bhs_lo, lut_me1bhs_hi,
        input  lut_me1ahs_lo, lut_me1ahs_hi,
        input  lut_me1a
    );

    modport slave (
        input  lut_cluster, lut_vpf, lut_roll,
        input  lut_pad, lut_size,
        output lut_wire_lo, lut_wire_hi,
        output lut_me1bhs_lo, lut_me1bhs_hi,
        output lut_me1ahs_lo, lut_me1ahs_hi,
        output lut_me1a
    );
endinterface

// File: rtl/gem_cluster_lut_sequencer.sv
// Shares one cluster->CSC LUT converter across a frame of GEM clusters.
// Define GEM_SEQ_SKIP_INVALID_EN to issue only slots with vpf set.
module gem_cluster_lut_sequencer #(
    parameter int NCLUSTERS   = 8,
    parameter int SLOTBITS    = 3,
    parameter int LUT_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      global_reset,
    input  logic                      frame_start,
    input  logic [14*NCLUSTERS-1:0]   cl_cluster,
    input  logic [NCLUSTERS-1:0]      cl_vpf,
    input  logic [3*NCLUSTERS-1:0]    cl_roll,
    input  logic [8*NCLUSTERS-1:0]    cl_pad,
    input  logic [3*NCLUSTERS-1:0]    cl_size,
    gem_cluster_lut_sequencer_if.master lut,
    output logic [6*NCLUSTERS-1:0]    res_wire_lo,
    output logic [6*NCLUSTERS-1:0]    res_wire_hi,
    output logic [8*NCLUSTERS-1:0]    res_me1bhs_lo,
    output logic [8*NCLUSTERS-1:0]    res_me1bhs_hi,
    output logic [8*NCLUSTERS-1:0]    res_me1ahs_lo,
    output logic [8*NCLUSTERS-1:0]    res_me1ahs_hi,
    output logic [NCLUSTERS-1:0]      res_me1a,
    output logic [NCLUSTERS-1:0]      res_vpf,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [14*NCLUSTERS-1:0] cluster_q;
    logic [NCLUSTERS-1:0]    vpf_q;
    logic [3*NCLUSTERS-1:0]  roll_q;
    logic [8*NCLUSTERS-1:0]  pad_q;
    logic [3*NCLUSTERS-1:0]  size_q;

    logic [NCLUSTERS-1:0]    pending;
    logic [NCLUSTERS-1:0]    elig_in;
    logic [NCLUSTERS-1:0]    pending_nx;
    logic [SLOTBITS-1:0]     pick;

    // Issue register sits alongside lut_*; tag pipe then matches LUT delay.
    logic                    iss_valid;
    logic [SLOTBITS-1:0]     iss_slot;
    logic [LUT_LATENCY-1:0]  tag_v;
    logic [SLOTBITS-1:0]     tag_s [LUT_LATENCY];

    logic                    pipe_busy;
    logic                    cap_v;
    logic [SLOTBITS-1:0]     cap_s;
    logic                    can_accept;

`ifdef GEM_SEQ_SKIP_INVALID_EN
    assign elig_in = cl_vpf;
`else
    assign elig_in = '1;
`endif

    always_comb begin
        pick = '0;
        for (int i = NCLUSTERS - 1; i >= 0; i--) begin
            if (pending[i]) pick = SLOTBITS'(i);
        end
    end

    assign pending_nx = pending & ~(NCLUSTERS'(1) << pick);

    // Last tag stage is captured on the same edge DRAIN may exit.
    always_comb begin
        pipe_busy = iss_valid;
        for (int k = 0; k < LUT_LATENCY - 1; k++) begin
            pipe_busy = pipe_busy | tag_v[k];
        end
    end

    assign cap_v      = tag_v[LUT_LATENCY-1];
    assign cap_s      = tag_s[LUT_LATENCY-1];
    assign can_accept = (state == IDLE) || (state == DONE);

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state           <= IDLE;
            cluster_q       <= '0;
            vpf_q           <= '0;
            roll_q          <= '0;
            pad_q           <= '0;
            size_q          <= '0;
            pending         <= '0;
            iss_valid       <= 1'b0;
            iss_slot        <= '0;
            tag_v           <= '0;
            for (int k = 0; k < LUT_LATENCY; k++) begin
                tag_s[k] <= '0;
            end
            lut.lut_cluster <= '0;
            lut.lut_vpf     <= 1'b0;
            lut.lut_roll    <= '0;
            lut.lut_pad     <= '0;
            lut.lut_size    <= '0;
            res_wire_lo     <= '0;
            res_wire_hi     <= '0;
            res_me1bhs_lo   <= '0;
            res_me1bhs_hi   <= '0;
            res_me1ahs_lo   <= '0;
            res_me1ahs_hi   <= '0;
            res_me1a        <= '0;
            res_vpf         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            iss_valid   <= 1'b0;
            lut.lut_vpf <= 1'b0;
            done        <= 1'b0;

            tag_v[0] <= iss_valid;
            tag_s[0] <= iss_slot;
            for (int k = 1; k < LUT_LATENCY; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_s[k] <= tag_s[k-1];
            end

            if (frame_start && !can_accept) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (cap_v) begin
                res_wire_lo[int'(cap_s)*6 +: 6]   <= lut.lut_wire_lo;
                res_wire_hi[int'(cap_s)*6 +: 6]   <= lut.lut_wire_hi;
                res_me1bhs_lo[int'(cap_s)*8 +: 8] <= lut.lut_me1bhs_lo;
                res_me1bhs_hi[int'(cap_s)*8 +: 8] <= lut.lut_me1bhs_hi;
                res_me1ahs_lo[int'(cap_s)*8 +: 8] <= lut.lut_me1ahs_lo;
                res_me1ahs_hi[int'(cap_s)*8 +: 8] <= lut.lut_me1ahs_hi;
                res_me1a[cap_s]                   <= lut.lut_me1a;
                res_vpf[cap_s]                    <= vpf_q[cap_s];
            end

            unique case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (frame_start) begin
                        cluster_q     <= cl_cluster;
                        vpf_q         <= cl_vpf;
                        roll_q        <= cl_roll;
                        pad_q         <= cl_pad;
                        size_q        <= cl_size;
                        pending       <= elig_in;
                        res_wire_lo   <= '0;
                        res_wire_hi   <= '0;
                        res_me1bhs_lo <= '0;
                        res_me1bhs_hi <= '0;
                        res_me1ahs_lo <= '0;
                        res_me1ahs_hi <= '0;
                        res_me1a      <= '0;
                        res_vpf       <= '0;
                        if (|elig_in) begin
                            state <= SCAN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    iss_valid       <= 1'b1;
                    iss_slot        <= pick;
                    lut.lut_cluster <= cluster_q[int'(pick)*14 +: 14];
                    lut.lut_vpf     <= vpf_q[pick];
                    lut.lut_roll    <= roll_q[int'(pick)*3 +: 3];
                    lut.lut_pad     <= pad_q[int'(pick)*8 +: 8];
                    lut.lut_size    <= size_q[int'(pick)*3 +: 3];
                    pending         <= pending_nx;
                    if (pending_nx == '0) state <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gem_cluster_lut_sequencer.sv
// Scoreboard bench for gem_cluster_lut_sequencer with a stub LUT converter.
// Honours GEM_SEQ_SKIP_INVALID_EN when building expected frames.
module tb_gem_cluster_lut_sequencer;

    localparam int NC  = 8;
    localparam int SB  = 3;
    localparam int LAT = 2;
    localparam int RW  = 46;
`ifdef GEM_SEQ_SKIP_INVALID_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clock = 1'b0;
    logic global_reset = 1'b1;
    logic frame_start = 1'b0;
    logic overrun_clr = 1'b0;
    logic [14*NC-1:0] cl_cluster = '0;
    logic [NC-1:0]    cl_vpf = '0;
    logic [3*NC-1:0]  cl_roll = '0;
    logic [8*NC-1:0]  cl_pad = '0;
    logic [3*NC-1:0]  cl_size = '0;
    logic [6*NC-1:0]  res_wire_lo, res_wire_hi;
    logic [8*NC-1:0]  res_me1bhs_lo, res_me1bhs_hi;
    logic [8*NC-1:0]  res_me1ahs_lo, res_me1ahs_hi;
    logic [NC-1:0]    res_me1a, res_vpf;
    logic             busy, done, overrun;

    gem_cluster_lut_sequencer_if lut ();

    gem_cluster_lut_sequencer #(
        .NCLUSTERS(NC), .SLOTBITS(SB), .LUT_LATENCY(LAT)
    ) dut (
        .clock(clock), .global_reset(global_reset),
        .frame_start(frame_start),
        .cl_cluster(cl_cluster), .cl_vpf(cl_vpf),
        .cl_roll(cl_roll), .cl_pad(cl_pad), .cl_size(cl_size),
        .lut(lut),
        .res_wire_lo(res_wire_lo), .res_wire_hi(res_wire_hi),
        .res_me1bhs_lo(res_me1bhs_lo), .res_me1bhs_hi(res_me1bhs_hi),
        .res_me1ahs_lo(res_me1ahs_lo), .res_me1ahs_hi(res_me1ahs_hi),
        .res_me1a(res_me1a), .res_vpf(res_vpf),
        .busy(busy), .done(done), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clock = ~clock;

    function automatic logic [44:0] conv(
        input logic [13:0] c, input logic [7:0] p,
        input logic [2:0] r, input logic [2:0] s);
        logic [5:0] wl, wh;
        logic [7:0] bl, bh, al, ah;
        wl = p[5:0];
        wh = p[5:0] ^ {r, 3'b101};
        bl = c[7:0];
        bh = c[13:6];
        al = p ^ {r, s, 2'b11};
        ah = c[13:6] + p;
        return {r[2], wl, wh, bl, bh, al, ah};
    endfunction

    // Stub converter: LAT registered stages from lut_* to results.
    logic [44:0] cv [LAT];
    always @(posedge clock) begin
        cv[0] <= conv(lut.lut_cluster, lut.lut_pad,
                      lut.lut_roll, lut.lut_size);
        for (int k = 1; k < LAT; k++) cv[k] <= cv[k-1];
    end
    assign {lut.lut_me1a, lut.lut_wire_lo, lut.lut_wire_hi,
            lut.lut_me1bhs_lo, lut.lut_me1bhs_hi,
            lut.lut_me1ahs_lo, lut.lut_me1ahs_hi} = cv[LAT-1];

    typedef struct packed {
        logic [31:0]      start;
        logic [31:0]      lat;
        logic [31:0]      npulse;
        logic [NC*RW-1:0] res;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h",
                     tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] slot_obs(input int s);
        return {res_vpf[s], res_me1a[s],
                res_wire_lo[6*s +: 6], res_wire_hi[6*s +: 6],
                res_me1bhs_lo[8*s +: 8], res_me1bhs_hi[8*s +: 8],
                res_me1ahs_lo[8*s +: 8], res_me1ahs_hi[8*s +: 8]};
    endfunction

    function automatic exp_t build(input logic [NC-1:0] v,
                                   input int st);
        exp_t e;
        int en;
        e.res = '0;
        en = 0;
        for (int s = 0; s < NC; s++) begin
            if (!SKIP || v[s]) begin
                en++;
                e.res[s*RW +: RW] = {v[s],
                    conv(cl_cluster[14*s +: 14], cl_pad[8*s +: 8],
                         cl_roll[3*s +: 3], cl_size[3*s +: 3])};
            end
        end
        e.npulse = 32'($countones(v));
        e.lat    = (en == 0) ? 32'd1 : 32'(en + LAT + 1);
        e.start  = 32'(st);
        return e;
    endfunction

    task automatic rand_fields(input logic [NC-1:0] v);
        for (int s = 0; s < NC; s++) begin
            cl_cluster[14*s +: 14] = 14'($urandom);
            cl_roll[3*s +: 3]      = 3'($urandom);
            cl_pad[8*s +: 8]       = 8'($urandom);
            cl_size[3*s +: 3]      = 3'($urandom);
        end
        cl_vpf = v;
    endtask

    // Called at a negedge; frame_start is sampled on the next posedge.
    task automatic frame(input bit accept);
        frame_start = 1'b1;
        if (accept) q.push_back(build(cl_vpf, cyc + 1));
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++)
            @(negedge clock);
        check("frame_timeout", 64'(q.size()), 64'd0);
    endtask

    exp_t me;
    always @(posedge clock) begin
        #1;
        if (global_reset) begin
            q.delete();
            pulses = 0;
        end else begin
            if (lut.lut_vpf) pulses++;
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    me = q.pop_front();
                    check("latency", 64'(cyc - int'(me.start)),
                          64'(me.lat));
                    check("lut_vpf_pulses", 64'(pulses),
                          64'(me.npulse));
                    check("busy_at_done", 64'(busy), 64'd0);
                    for (int s = 0; s < NC; s++)
                        check($sformatf("slot%0d", s),
                              64'(slot_obs(s)),
                              64'(me.res[s*RW +: RW]));
                end
                pulses = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_res_vpf", 64'(res_vpf), 64'd0);
        check("rst_res_wire_lo", 64'(res_wire_lo), 64'd0);
        check("rst_lut_vpf", 64'(lut.lut_vpf), 64'd0);
        check("rst_lut_cluster", 64'(lut.lut_cluster), 64'd0);
        global_reset = 1'b0;
        @(negedge clock);

        rand_fields(8'h05);
        cl_pad[7:0]   = 8'd10;
        cl_roll[2:0]  = 3'd2;
        cl_pad[23:16] = 8'd100;
        cl_roll[8:6]  = 3'd7;
        frame(1'b1);
        wait_idle();
        check("a_me1a_bit2", 64'(res_me1a[2]), 64'd1);
        check("a_me1a_bit0", 64'(res_me1a[0]), 64'd0);

        rand_fields(8'h00);
        frame(1'b1);
        wait_idle();

        rand_fields(8'hFF);
        frame(1'b1);
        wait_idle();

        rand_fields(8'hFF);
        frame(1'b1);
        @(negedge clock);
        @(negedge clock);
        rand_fields(8'h0F);
        frame(1'b0);
        check("ovr_set", 64'(overrun), 64'd1);
        frame_start = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        overrun_clr = 1'b0;
        check("ovr_prio", 64'(overrun), 64'd1);
        check("ovr_busy", 64'(busy), 64'd1);
        wait_idle();
        check("ovr_hold", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        @(negedge clock);
        overrun_clr = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);

        rand_fields(8'hFF);
        frame(1'b1);
        @(negedge clock);
        global_reset = 1'b1;
        @(negedge clock);
        global_reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_res_vpf", 64'(res_vpf), 64'd0);
        check("mid_rst_ahs_hi", 64'(res_me1ahs_hi), 64'd0);
        check("mid_rst_lut_vpf", 64'(lut.lut_vpf), 64'd0);
        @(negedge clock);
        rand_fields(8'h5A);
        frame(1'b1);
        wait_idle();

        rand_fields(8'h3C);
        frame(1'b1);
        for (int i = 0; i < 100 && done !== 1'b1; i++)
            @(negedge clock);
        check("coin_done_seen", 64'(done), 64'd1);
        rand_fields(8'h81);
        frame(1'b1);
        check("coin_busy", 64'(busy), 64'd1);
        check("coin_res_vpf", 64'(res_vpf), 64'd0);
        wait_idle();

        repeat (4) @(negedge clock);
        check("q_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
